coproc_stream_ctrl: RTL and testbench
=====================================

# coproc_stream_ctrl

Stream-side controller for the matrix-multiply coprocessor. Accepts one AXI-Stream input frame (matrix A then vector B), writes it into A_RAM and B_RAM, and drives the matrix_multiply Start/Done handshake. It then reads RES_RAM and emits the results as one AXI-Stream output frame. It sits between the AXI-Stream ports of the IP and the three RAMs/matrix_multiply instance, directly upstream and downstream of the multiply unit.

## Interface
- width, 8, bits per data word (stream and RAM).
- A_depth_bits, 3, A_RAM address bits; A_len = 2^A_depth_bits words.
- B_depth_bits, 2, B_RAM address bits; B_len = 2^B_depth_bits words.
- RES_depth_bits, A_depth_bits-B_depth_bits, RES_RAM address bits; RES_len = 2^RES_depth_bits words.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  width  input word.
- s_axis_tvalid  in  1  input word valid.
- s_axis_tready  out  1  controller can accept a word.
- s_axis_tlast  in  1  upstream end-of-frame marker.
- m_axis_tdata  out  width  result word.
- m_axis_tvalid  out  1  result word valid.
- m_axis_tready  in  1  downstream accepts the result word.
- m_axis_tlast  out  1  last result word of the frame.
- A_write_en / A_write_address / A_write_data_in  out  1 / A_depth_bits / width  A_RAM write port.
- B_write_en / B_write_address / B_write_data_in  out  1 / B_depth_bits / width  B_RAM write port.
- Start  out  1  held high while matrix_multiply runs.
- Done  in  1  one-cycle completion pulse from matrix_multiply.
- RES_read_en / RES_read_address  out  1 / RES_depth_bits  RES_RAM synchronous read port.
- RES_read_data_out  in  width  RES_RAM data, valid 1 cycle after the read.
- rx_err  out  1  sticky TLAST protocol error (see Configuration).

## Operation
- States: RECV, COMPUTE, SEND_RD, SEND_LAT, SEND_OUT.
- RECV: s_axis_tready=1. Word counter k counts 0..A_len+B_len-1, one step per handshake (tvalid&tready).
  - Word k<A_len goes to A_RAM address k. Otherwise it goes to B_RAM address k-A_len.
  - Writes are registered: A/B_write_en=1 with address and data in the cycle after the handshake, else 0.
  - On the handshake of word A_len+B_len-1: k is cleared and the state moves to COMPUTE.
- COMPUTE: s_axis_tready=0. Start rises one cycle after COMPUTE entry, which is after the final B write cycle. Start stays high until Done=1 is sampled. At that edge Start becomes 0 and the state moves to SEND_RD with r=0.
- SEND_RD: RES_read_en=1 and RES_read_address=r for one cycle, then go to SEND_LAT.
- SEND_LAT: at the end of this cycle, RES_read_data_out is captured into m_axis_tdata and m_axis_tvalid is set. Go to SEND_OUT.
- SEND_OUT: m_axis_tvalid=1. m_axis_tlast=(r==RES_len-1). tdata, tvalid and tlast stay stable until m_axis_tready=1.
  - On the handshake: m_axis_tvalid and m_axis_tlast are cleared.
  - If r==RES_len-1, go to RECV. Otherwise increment r and go to SEND_RD.
- Data passes through unmodified. No arithmetic is done here; truncation to width is the multiply unit's responsibility.
- Done pulses outside COMPUTE are ignored.

## Timing
- Reset values (and values while reset is high): state=RECV, k=r=0, every output 0 (s_axis_tready included). s_axis_tready goes to 1 in the first cycle after reset falls.
- Reset mid-frame, mid-compute or mid-send:
  - At the next edge, Start, the write enables, RES_read_en and m_axis_tvalid are 0.
  - Partial input is discarded and no partial output frame is completed.
  - Stale RAM contents are overwritten by the next frame.
- Input throughput is 1 word/cycle. Bubbles on s_axis_tvalid do not advance k.
- Output takes at least 3 cycles per word: SEND_RD, then SEND_LAT, then SEND_OUT for ≥1 cycle.
- Start is low for at least 3 cycles between runs, which guarantees matrix_multiply re-initialises.
- Latency from last input handshake to Start=1 is 2 cycles.

## Configuration
- Macro TLAST_CHECK_EN.
- Defined: rx_err is set (sticky until reset) in either case:
  - s_axis_tlast=1 on a handshake with k≠A_len+B_len-1;
  - s_axis_tlast=0 on the handshake with k=A_len+B_len-1.
  - Frame length is still determined by the counter.
- Not defined: s_axis_tlast is ignored and rx_err is tied to 0.

## Test plan
- Single frame with a real matrix_multiply and RAMs:
  - Stimulus: A=1,2,3,4,5,6,7,8 and B=1,1,1,1, then Done.
  - Response: Start rises 2 cycles after the last input handshake and falls after Done; m_axis emits 10 then 26, with tlast only on 26.
- Input bubbles: the same frame with tvalid low for 1–3 random cycles between words -> identical A/B writes (address k, data k+1) and identical output 10, 26.
- Output backpressure: m_axis_tready low for 5 cycles while tvalid=1 -> tdata=10 held stable with tvalid held. Accepting it yields 26 at least 3 cycles later.
- Back-to-back frames:
  - Stimulus: frame 1 as above, then frame 2 with A all 2 and B all 3.
  - Response: Start low for ≥1 cycle between runs; outputs 10, 26, then 24, 24.
- Reset after 5 input words, then a full frame 1 -> no Start until the new frame is complete; output 10, 26.
- TLAST_CHECK_EN:
  - Defined: tlast=1 on word 3 -> rx_err=1 and stays 1 through the frame; output is still produced.
  - Not defined: the same stimulus leaves rx_err=0.

Source files
------------

// File: rtl/coproc_stream_ctrl.sv
// coproc_stream_ctrl: stream-side controller for the matrix-multiply coprocessor.
// Receives one AXI-Stream frame (A words then B words) into A_RAM/B_RAM, runs the
// Start/Done handshake with matrix_multiply, then streams RES_RAM out as one frame.
// Optional macro TLAST_CHECK_EN: when defined, rx_err flags TLAST placement errors;
// when undefined, s_axis_tlast is ignored and rx_err is tied low.
module coproc_stream_ctrl #(
  parameter int width          = 8,
  parameter int A_depth_bits   = 3,
  parameter int B_depth_bits   = 2,
  parameter int RES_depth_bits = A_depth_bits - B_depth_bits
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [width-1:0]          s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  output logic [width-1:0]          m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic                      A_write_en,
  output logic [A_depth_bits-1:0]   A_write_address,
  output logic [width-1:0]          A_write_data_in,
  output logic                      B_write_en,
  output logic [B_depth_bits-1:0]   B_write_address,
  output logic [width-1:0]          B_write_data_in,
  output logic                      Start,
  input  logic                      Done,
  output logic                      RES_read_en,
  output logic [RES_depth_bits-1:0] RES_read_address,
  input  logic [width-1:0]          RES_read_data_out,
  output logic                      rx_err
);

  localparam int A_len   = 1 << A_depth_bits;
  localparam int B_len   = 1 << B_depth_bits;
  localparam int RES_len = 1 << RES_depth_bits;
  // One extra bit above the A address: k[A_depth_bits] set means "B section".
  localparam int KW      = A_depth_bits + 1;
  localparam logic [KW-1:0]             K_LAST = KW'(A_len + B_len - 1);
  localparam logic [RES_depth_bits-1:0] R_LAST = RES_depth_bits'(RES_len - 1);

  typedef enum logic [2:0] {RECV, COMPUTE, SEND_RD, SEND_LAT, SEND_OUT} state_t;

  state_t                    state_q, state_d;
  logic [KW-1:0]             k_q, k_d;
  logic [RES_depth_bits-1:0] r_q, r_d;
  logic                      arm_q, arm_d;      // first COMPUTE cycle passed
  logic                      tready_q, tready_d;
  logic                      a_we_q, a_we_d;
  logic [A_depth_bits-1:0]   a_addr_q, a_addr_d;
  logic [width-1:0]          a_data_q, a_data_d;
  logic                      b_we_q, b_we_d;
  logic [B_depth_bits-1:0]   b_addr_q, b_addr_d;
  logic [width-1:0]          b_data_q, b_data_d;
  logic                      start_q, start_d;
  logic                      rd_en_q, rd_en_d;
  logic [RES_depth_bits-1:0] rd_addr_q, rd_addr_d;
  logic [width-1:0]          tdata_q, tdata_d;
  logic                      tvalid_q, tvalid_d;
  logic                      tlast_q, tlast_d;
  logic                      rx_err_q, rx_err_d;

  logic hs_in, hs_out, k_last;
  assign hs_in  = s_axis_tvalid & tready_q;
  assign hs_out = tvalid_q & m_axis_tready;
  assign k_last = (k_q == K_LAST);

  // Next-state and registered-output computation for the whole controller.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    r_d       = r_q;
    arm_d     = arm_q;
    tready_d  = tready_q;
    a_we_d    = 1'b0;
    a_addr_d  = a_addr_q;
    a_data_d  = a_data_q;
    b_we_d    = 1'b0;
    b_addr_d  = b_addr_q;
    b_data_d  = b_data_q;
    start_d   = start_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    rx_err_d  = rx_err_q;
    case (state_q)
      RECV: begin
        tready_d = 1'b1;
        if (hs_in) begin
          if (!k_q[A_depth_bits]) begin
            a_we_d   = 1'b1;
            a_addr_d = k_q[A_depth_bits-1:0];
            a_data_d = s_axis_tdata;
          end else begin
            // A_len is a multiple of B_len, so the low bits are k-A_len.
            b_we_d   = 1'b1;
            b_addr_d = k_q[B_depth_bits-1:0];
            b_data_d = s_axis_tdata;
          end
`ifdef TLAST_CHECK_EN
          if (s_axis_tlast != k_last) rx_err_d = 1'b1;
`endif
          if (k_last) begin
            k_d      = '0;
            state_d  = COMPUTE;
            tready_d = 1'b0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      COMPUTE: begin
        tready_d = 1'b0;
        // Hold Start off for the first COMPUTE cycle so the final B write lands first.
        if (!arm_q) begin
          arm_d = 1'b1;
        end else if (!start_q) begin
          start_d = 1'b1;
        end else if (Done) begin
          start_d   = 1'b0;
          arm_d     = 1'b0;
          r_d       = '0;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          state_d   = SEND_RD;
        end
      end
      SEND_RD: state_d = SEND_LAT;
      SEND_LAT: begin
        tdata_d  = RES_read_data_out;
        tvalid_d = 1'b1;
        tlast_d  = (r_q == R_LAST);
        state_d  = SEND_OUT;
      end
      SEND_OUT: begin
        if (hs_out) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          if (r_q == R_LAST) begin
            r_d      = '0;
            tready_d = 1'b1;
            state_d  = RECV;
          end else begin
            r_d       = r_q + 1'b1;
            rd_en_d   = 1'b1;
            rd_addr_d = r_q + 1'b1;
            state_d   = SEND_RD;
          end
        end
      end
      default: state_d = RECV;
    endcase
  end

  // State and output registers; reset drops every output and discards partial work.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RECV;
      k_q       <= '0;
      r_q       <= '0;
      arm_q     <= 1'b0;
      tready_q  <= 1'b0;
      a_we_q    <= 1'b0;
      a_addr_q  <= '0;
      a_data_q  <= '0;
      b_we_q    <= 1'b0;
      b_addr_q  <= '0;
      b_data_q  <= '0;
      start_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      rx_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      r_q       <= r_d;
      arm_q     <= arm_d;
      tready_q  <= tready_d;
      a_we_q    <= a_we_d;
      a_addr_q  <= a_addr_d;
      a_data_q  <= a_data_d;
      b_we_q    <= b_we_d;
      b_addr_q  <= b_addr_d;
      b_data_q  <= b_data_d;
      start_q   <= start_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      rx_err_q  <= rx_err_d;
    end
  end

  assign s_axis_tready    = tready_q;
  assign A_write_en       = a_we_q;
  assign A_write_address  = a_addr_q;
  assign A_write_data_in  = a_data_q;
  assign B_write_en       = b_we_q;
  assign B_write_address  = b_addr_q;
  assign B_write_data_in  = b_data_q;
  assign Start            = start_q;
  assign RES_read_en      = rd_en_q;
  assign RES_read_address = rd_addr_q;
  assign m_axis_tdata     = tdata_q;
  assign m_axis_tvalid    = tvalid_q;
  assign m_axis_tlast     = tlast_q;

`ifdef TLAST_CHECK_EN
  assign rx_err = rx_err_q;
`else
  // TLAST is ignored in this build; frame length comes from the counter alone.
  logic tlast_unused;
  assign tlast_unused = s_axis_tlast;
  assign rx_err       = 1'b0;
`endif

endmodule

// File: tb/tb_coproc_stream_ctrl.sv
// Bench for coproc_stream_ctrl with behavioural RAMs and a matrix_multiply model.
module tb_coproc_stream_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic       A_write_en;
  logic [2:0] A_write_address;
  logic [7:0] A_write_data_in;
  logic       B_write_en;
  logic [1:0] B_write_address;
  logic [7:0] B_write_data_in;
  logic       Start, Done;
  logic       RES_read_en;
  logic [0:0] RES_read_address;
  logic [7:0] RES_read_data_out;
  logic       rx_err;

  coproc_stream_ctrl dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .A_write_en(A_write_en), .A_write_address(A_write_address), .A_write_data_in(A_write_data_in),
    .B_write_en(B_write_en), .B_write_address(B_write_address), .B_write_data_in(B_write_data_in),
    .Start(Start), .Done(Done),
    .RES_read_en(RES_read_en), .RES_read_address(RES_read_address),
    .RES_read_data_out(RES_read_data_out), .rx_err(rx_err)
  );

  always #5 clk = ~clk;

  int ntot = 0, npass = 0, cyc = 0, last_hs = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // RAM models and matrix_multiply model
  logic [7:0] aram [8];
  logic [7:0] bram [4];
  logic [7:0] res_mem [2];
  logic mm_done = 1'b0, spur_done = 1'b0;
  int   mm_cnt = 0;
  assign Done = mm_done | spur_done;

  always @(posedge clk) begin
    if (A_write_en) aram[A_write_address] <= A_write_data_in;
    if (B_write_en) bram[B_write_address] <= B_write_data_in;
    if (RES_read_en) RES_read_data_out <= res_mem[RES_read_address];
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      mm_done = 1'b0;
      if (!Start) mm_cnt = 0;
      else if (mm_cnt < 4) mm_cnt++;
      else if (mm_cnt == 4) begin
        for (int i = 0; i < 2; i++) begin
          logic [7:0] s;
          s = 8'd0;
          for (int j = 0; j < 4; j++) s = s + aram[i*4+j] * bram[j];
          res_mem[i] = s;
        end
        mm_done = 1'b1;
        mm_cnt  = 5;
      end
    end
  end

  // Scoreboards: expected RAM writes and expected output words
  typedef struct packed { logic [7:0] d; logic l; } exp_t;
  exp_t        exp_q[$];
  logic [11:0] exp_w[$];   // {is_b, addr[2:0], data}

  task automatic push_out(input logic [7:0] a, input logic [7:0] b);
    exp_q.push_back('{d: a, l: 1'b0});
    exp_q.push_back('{d: b, l: 1'b1});
  endtask

  // Monitor, sampling on the falling edge
  initial begin
    logic st_prev = 1'b0, tv_prev = 1'b0, have_fall = 1'b0, have_hs = 1'b0;
    int   fall_cyc = 0, hs_cyc = 0;
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (A_write_en || B_write_en) begin
        if (exp_w.size() == 0) chk("wr_extra", 1, 0);
        else begin
          e = exp_w.pop_front();
          if (A_write_en) chk("a_wr", {1'b0, A_write_address, A_write_data_in}, e);
          else            chk("b_wr", {1'b1, 1'b0, B_write_address, B_write_data_in}, e);
        end
      end
      if (Start && !st_prev) begin
        chk("start_lat", cyc - last_hs, 2);
        if (have_fall) chk("start_gap_ge3", (cyc - fall_cyc) >= 3, 1);
      end
      if (!Start && st_prev) begin fall_cyc = cyc; have_fall = 1'b1; end
      if (mm_done) chk("start_at_done", Start, 1);
      if (m_axis_tvalid) begin
        if (!tv_prev && have_hs) chk("out_gap_ge3", (cyc - hs_cyc) >= 3, 1);
        if (exp_q.size() == 0) chk("out_extra", 1, 0);
        else begin
          chk("tdata", m_axis_tdata, exp_q[0].d);
          chk("tlast", m_axis_tlast, exp_q[0].l);
          if (m_axis_tready) begin
            void'(exp_q.pop_front());
            hs_cyc  = cyc;
            have_hs = 1'b1;
          end
        end
      end
      st_prev = Start;
      tv_prev = m_axis_tvalid && !m_axis_tready;
    end
  end

  // Stimulus
  logic [7:0] fa [12];

  task automatic send_word(input logic [7:0] d, input bit lst, input int idx);
    int n = 0;
    bit hs = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = lst;
    s_axis_tvalid = 1'b1;
    if (idx < 8) exp_w.push_back({1'b0, 3'(idx), d});
    else         exp_w.push_back({1'b1, 3'(idx - 8), d});
    while (!hs && n < 200) begin
      @(negedge clk); hs = s_axis_tready;
      @(posedge clk); #1; n++;
    end
    if (!hs) chk("in_hs_timeout", 0, 1);
    last_hs = cyc;
  endtask

  task automatic send_frame(input int max_bub, input int tl_idx);
    for (int i = 0; i < 12; i++) begin
      send_word(fa[i], (i == 11) || (i == tl_idx), i);
      if (max_bub > 0 && i < 11) begin
        s_axis_tvalid = 1'b0;
        repeat ($urandom_range(max_bub, 1)) begin @(posedge clk); #1; end
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic load_frame1();
    for (int i = 0; i < 8; i++) fa[i] = 8'(i + 1);
    for (int i = 8; i < 12; i++) fa[i] = 8'd1;
  endtask

  task automatic wait_out();
    int n = 0;
    while ((exp_q.size() != 0 || exp_w.size() != 0) && n < 1000) begin @(posedge clk); #1; n++; end
    chk("drain_out", exp_q.size(), 0);
    chk("drain_wr", exp_w.size(), 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {s_axis_tready, Start, A_write_en, B_write_en, RES_read_en,
                     m_axis_tvalid, m_axis_tlast, rx_err}, 0);
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;
    chk("tready_after_rst", s_axis_tready, 1);

    // Done outside COMPUTE must not start anything
    spur_done = 1'b1; @(posedge clk); #1; spur_done = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("spur_done_start", Start, 0);
    chk("spur_done_tready", s_axis_tready, 1);

    // Plain frame
    load_frame1(); push_out(8'd10, 8'd26);
    send_frame(0, -1); wait_out();
    chk("rx_err_clean", rx_err, 0);

    // Input bubbles
    push_out(8'd10, 8'd26);
    send_frame(3, -1); wait_out();

    // Output backpressure
    m_axis_tready = 1'b0;
    push_out(8'd10, 8'd26);
    send_frame(0, -1);
    n = 0;
    while (!m_axis_tvalid && n < 100) begin @(posedge clk); #1; n++; end
    chk("bp_wait", m_axis_tvalid, 1);
    repeat (5) begin @(negedge clk); chk("bp_valid_held", m_axis_tvalid, 1); end
    @(posedge clk); #1; m_axis_tready = 1'b1;
    wait_out();

    // Back-to-back frames
    push_out(8'd10, 8'd26); push_out(8'd24, 8'd24);
    send_frame(0, -1);
    for (int i = 0; i < 8; i++) fa[i] = 8'd2;
    for (int i = 8; i < 12; i++) fa[i] = 8'd3;
    send_frame(0, -1);
    wait_out();

    // Reset after 5 input words, then a full frame
    load_frame1();
    for (int i = 0; i < 5; i++) send_word(fa[i], 1'b0, i);
    s_axis_tvalid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_outs", {s_axis_tready, Start, A_write_en, B_write_en, RES_read_en, m_axis_tvalid}, 0);
    chk("midrst_wr_q", exp_w.size(), 0);
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("midrst_nostart", Start, 0);
    push_out(8'd10, 8'd26);
    send_frame(0, -1); wait_out();

    // Misplaced TLAST on word 3
    push_out(8'd10, 8'd26);
    for (int i = 0; i < 6; i++) send_word(fa[i], (i == 3), i);
`ifdef TLAST_CHECK_EN
    chk("rx_err_mid", rx_err, 1);
`else
    chk("rx_err_mid", rx_err, 0);
`endif
    for (int i = 6; i < 12; i++) send_word(fa[i], (i == 11), i);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    wait_out();
`ifdef TLAST_CHECK_EN
    chk("rx_err_end", rx_err, 1);
`else
    chk("rx_err_end", rx_err, 0);
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
